// File: rtl/shapool_io_pkg.sv
// Shared widths for the shapool external I/O front end.
package shapool_io_pkg;

  localparam int JOB_CONFIG_WIDTH_DEF    = 352;
  localparam int DEVICE_CONFIG_WIDTH_DEF = 8;
  localparam int MATCH_FLAGS_WIDTH_DEF   = 8;
  localparam int NONCE_WIDTH_DEF         = 32;
  localparam int RESULT_WIDTH_DEF        = MATCH_FLAGS_WIDTH_DEF + NONCE_WIDTH_DEF;

  // SPI1 has two personalities: config daisy chain, then result readout.
  typedef enum logic {
    SPI1_CONFIG = 1'b0,
    SPI1_RESULT = 1'b1
  } spi1_mode_e;

endpackage

// File: rtl/spi_input_sync.sv
// Brings one SPI slave port into the clk domain: 2-FF synchronizers on
// sck/sdi/cs_n plus rise/fall strobes on the synchronized sck.
module spi_input_sync (
  input  logic clk,
  input  logic i_sck,
  input  logic i_sdi,
  input  logic i_cs_n,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_active,
  output logic o_sdi_sync
);

  // r_sck[2] is the delayed copy used only for edge detection.
  logic [2:0] r_sck;
  logic [1:0] r_sdi;
  logic [1:0] r_cs_n;

  // Synchronizer chains; deliberately unaffected by reset_n because
  // configuration is shifted in while the device is held in reset.
  // NOTE: no reset on these flops on purpose -- a reset here would block
  // configuration loading; power-up contents settle within two clocks.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples the previous
    // stage's old value, giving a real two-flop chain.
    r_sck  <= {r_sck[1:0], i_sck};
    r_sdi  <= {r_sdi[0], i_sdi};
    r_cs_n <= {r_cs_n[0], i_cs_n};
  end

  assign o_sck_rise  = r_sck[1] & ~r_sck[2];
  assign o_sck_fall  = ~r_sck[1] & r_sck[2];
  assign o_cs_active = ~r_cs_n[1];
  assign o_sdi_sync  = r_sdi[1];

endmodule

// File: rtl/external_io.sv
// External I/O front end of the shapool hashing device: job/device
// configuration shift registers, result latch with SPI1 readout, and the
// core reset synchronizer.
module external_io
  import shapool_io_pkg::*;
#(
  parameter int JOB_CONFIG_WIDTH    = JOB_CONFIG_WIDTH_DEF,
  parameter int DEVICE_CONFIG_WIDTH = DEVICE_CONFIG_WIDTH_DEF,
  parameter int MATCH_FLAGS_WIDTH   = MATCH_FLAGS_WIDTH_DEF,
  parameter int NONCE_WIDTH         = NONCE_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  sck0,
  input  logic                                  sdi0,
  input  logic                                  cs0_n,
  input  logic                                  sck1,
  input  logic                                  sdi1,
  output logic                                  sdo1,
  input  logic                                  cs1_n,
  output logic [DEVICE_CONFIG_WIDTH-1:0]        device_config,
  output logic [JOB_CONFIG_WIDTH-1:0]           job_config,
  output logic                                  core_reset_n,
  input  logic                                  success,
  input  logic [MATCH_FLAGS_WIDTH+NONCE_WIDTH-1:0] result,
  output logic                                  ready
);

  localparam int RESULT_WIDTH = MATCH_FLAGS_WIDTH + NONCE_WIDTH;

  logic w_sck0_rise;
  logic w_unused_sck0_fall;
  logic w_cs0_active;
  logic w_sdi0_sync;
  logic w_sck1_rise;
  logic w_sck1_fall;
  logic w_cs1_active;
  logic w_sdi1_sync;

  logic [JOB_CONFIG_WIDTH-1:0]    r_job_config;
  logic [DEVICE_CONFIG_WIDTH-1:0] r_device_config;
  logic [RESULT_WIDTH-1:0]        r_result_sr;
  logic                           r_sdi1_sampled;
  logic                           r_ready;
  logic [1:0]                     r_rst_sync;
  spi1_mode_e                     w_spi1_mode;

  spi_input_sync u_spi0_sync (
    .clk         (clk),
    .i_sck       (sck0),
    .i_sdi       (sdi0),
    .i_cs_n      (cs0_n),
    .o_sck_rise  (w_sck0_rise),
    .o_sck_fall  (w_unused_sck0_fall),
    .o_cs_active (w_cs0_active),
    .o_sdi_sync  (w_sdi0_sync)
  );

  spi_input_sync u_spi1_sync (
    .clk         (clk),
    .i_sck       (sck1),
    .i_sdi       (sdi1),
    .i_cs_n      (cs1_n),
    .o_sck_rise  (w_sck1_rise),
    .o_sck_fall  (w_sck1_fall),
    .o_cs_active (w_cs1_active),
    .o_sdi_sync  (w_sdi1_sync)
  );

  assign w_spi1_mode = r_ready ? SPI1_RESULT : SPI1_CONFIG;

  // Job configuration shift register; keeps its contents across reset_n.
  always_ff @(posedge clk) begin
    if (w_sck0_rise && w_cs0_active) begin
      r_job_config <= {r_job_config[JOB_CONFIG_WIDTH-2:0], w_sdi0_sync};
    end
  end

  // Device configuration shift register; frozen once a result is latched.
  always_ff @(posedge clk) begin
    if (w_spi1_mode == SPI1_CONFIG && w_sck1_rise && w_cs1_active) begin
      r_device_config <= {r_device_config[DEVICE_CONFIG_WIDTH-2:0], w_sdi1_sync};
    end
  end

  // Two-flop reset synchronizer: asynchronous assert, synchronous release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Result latch and readout shifter. r_rst_sync[0] gates the latch so a
  // success coinciding with the reset_n release edge is only taken on the
  // following edge. Daisy-chain data is sampled on sck1 rise and shifted
  // in on the next fall so sdo1 changes only while sck1 is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready        <= 1'b0;
      r_result_sr    <= '0;
      r_sdi1_sampled <= 1'b0;
    end else if (w_spi1_mode == SPI1_CONFIG) begin
      if (success && r_rst_sync[0]) begin
        r_result_sr <= result;
        r_ready     <= 1'b1;
      end
    end else begin
      if (w_sck1_rise && w_cs1_active) begin
        r_sdi1_sampled <= w_sdi1_sync;
      end
      if (w_sck1_fall && w_cs1_active) begin
        r_result_sr <= {r_result_sr[RESULT_WIDTH-2:0], r_sdi1_sampled};
      end
    end
  end

  // sdo1 is combinational so the result MSB is present before the first rise.
  always_comb begin
    // NOTE: default first so every path assigns sdo1 and no latch is inferred.
    sdo1 = r_device_config[DEVICE_CONFIG_WIDTH-1];
    if (w_spi1_mode == SPI1_RESULT) begin
      sdo1 = r_result_sr[RESULT_WIDTH-1];
    end
  end

  assign job_config    = r_job_config;
  assign device_config = r_device_config;
  assign core_reset_n  = r_rst_sync[1];
  assign ready         = r_ready;

endmodule

// File: tb/tb_external_io.sv
// Self-checking bench for external_io (8-bit job config instance).
module tb_external_io;

  logic        clk;
  logic        reset_n;
  logic        sck0, sdi0, cs0_n;
  logic        sck1, sdi1, cs1_n;
  logic        sdo1;
  logic [7:0]  device_config;
  logic [7:0]  job_config;
  logic        core_reset_n;
  logic        success;
  logic [39:0] result;
  logic        ready;

  int n_checks;
  int n_fail;

  // Expected sdo1 bits, pushed when a readout is started.
  logic sb_q[$];

  external_io #(
    .JOB_CONFIG_WIDTH    (8),
    .DEVICE_CONFIG_WIDTH (8),
    .MATCH_FLAGS_WIDTH   (8),
    .NONCE_WIDTH         (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sck0          (sck0),
    .sdi0          (sdi0),
    .cs0_n         (cs0_n),
    .sck1          (sck1),
    .sdi1          (sdi1),
    .sdo1          (sdo1),
    .cs1_n         (cs1_n),
    .device_config (device_config),
    .job_config    (job_config),
    .core_reset_n  (core_reset_n),
    .success       (success),
    .result        (result),
    .ready         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi0_bits(input logic [7:0] b, input int nbits, input logic use_cs);
    cs0_n = ~use_cs;
    wait_clk(3);
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi0 = b[i];
      wait_clk(3);
      sck0 = 1'b1;
      wait_clk(3);
      sck0 = 1'b0;
    end
    wait_clk(3);
    cs0_n = 1'b1;
    wait_clk(3);
  endtask

  // Shift a config byte into SPI1; optionally check sdo1 tracks the MSB
  // of a model register that starts at prev.
  task automatic spi1_config(input logic [7:0] b, input logic [7:0] prev, input logic track);
    logic [7:0] model;
    model = prev;
    cs1_n = 1'b0;
    wait_clk(3);
    for (int i = 7; i >= 0; i--) begin
      sdi1 = b[i];
      wait_clk(3);
      sck1 = 1'b1;
      model = {model[6:0], b[i]};
      wait_clk(3);
      if (track) check("sdo1_cfg_track", 64'(sdo1), 64'(model[7]));
      sck1 = 1'b0;
    end
    wait_clk(3);
    cs1_n = 1'b1;
    wait_clk(3);
  endtask

  // Clock nbits out of SPI1 in result mode, comparing each sdo1 bit against
  // the scoreboard before the rising edge.
  task automatic spi1_read(input int nbits, input logic [39:0] din);
    for (int i = 0; i < nbits; i++) begin
      sdi1 = din[39 - i];
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        check("sdo1_read", 64'(sdo1), 64'(sb_q.pop_front()));
      end
      sck1 = 1'b1;
      wait_clk(3);
      sck1 = 1'b0;
      wait_clk(3);
    end
  endtask

  initial begin
    logic [39:0] exp_res;
    logic [39:0] sdi_pat;
    logic [7:0]  ext_bits;
    logic [3:0]  tail_bits;
    n_checks = 0;
    n_fail   = 0;
    reset_n = 1'b0;
    sck0 = 1'b0; sdi0 = 1'b0; cs0_n = 1'b1;
    sck1 = 1'b0; sdi1 = 1'b0; cs1_n = 1'b1;
    success = 1'b0;
    result  = '0;

    // Reset state.
    wait_clk(5);
    check("rst_core_reset_n", 64'(core_reset_n), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);

    // SPI0 job configuration.
    spi0_bits(8'hAA, 8, 1'b1);
    check("job_cfg_aa", 64'(job_config), 64'hAA);
    spi0_bits(8'h00, 4, 1'b0);
    check("job_cfg_cs_high", 64'(job_config), 64'hAA);
    spi0_bits(8'hF0, 4, 1'b1);
    check("job_cfg_partial", 64'(job_config), 64'hAF);

    // SPI1 device configuration.
    spi1_config(8'h55, 8'h00, 1'b0);
    check("dev_cfg_55", 64'(device_config), 64'h55);
    spi1_config(8'hAA, 8'h55, 1'b1);
    check("dev_cfg_aa", 64'(device_config), 64'hAA);
    check("sdo1_cfg_msb", 64'(sdo1), 64'd1);

    // Release reset and present a result.
    reset_n = 1'b1;
    result  = 40'hAA_EEDDCCBB;
    success = 1'b1;
    wait_clk(1);
    check("core_rst_hold_1clk", 64'(core_reset_n), 64'd0);
    wait_clk(1);
    check("core_rst_rel_2clk", 64'(core_reset_n), 64'd1);
    for (int i = 0; i < 20 && !ready; i++) wait_clk(1);
    check("ready_latch", 64'(ready), 64'd1);
    success = 1'b0;

    // Later success with a different result must be ignored.
    wait_clk(2);
    result  = '0;
    success = 1'b1;
    wait_clk(1);
    success = 1'b0;
    wait_clk(2);
    check("ready_still", 64'(ready), 64'd1);

    // Readout: 40 result bits, then 8 daisy-chained bits.
    exp_res = 40'hAA_EEDDCCBB;
    sdi_pat = 40'h12_3456789A;
    for (int i = 39; i >= 0; i--) sb_q.push_back(exp_res[i]);
    ext_bits = sdi_pat[39:32];
    for (int i = 7; i >= 0; i--) sb_q.push_back(ext_bits[i]);
    cs1_n = 1'b0;
    wait_clk(3);
    spi1_read(40, sdi_pat);
    spi1_read(8, 40'h0);
    check("dev_cfg_frozen", 64'(device_config), 64'hAA);

    // Partial readout then reset_n low mid-transfer.
    tail_bits = sdi_pat[31:28];
    for (int i = 3; i >= 0; i--) sb_q.push_back(tail_bits[i]);
    spi1_read(4, 40'h0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_core", 64'(core_reset_n), 64'd0);
    check("mid_rst_sdo1", 64'(sdo1), 64'd1);
    cs1_n = 1'b1;
    wait_clk(3);
    check("mid_rst_dev_cfg", 64'(device_config), 64'hAA);
    check("mid_rst_job_cfg", 64'(job_config), 64'hAF);
    reset_n = 1'b1;
    wait_clk(1);
    check("core_rst2_1clk", 64'(core_reset_n), 64'd0);
    wait_clk(1);
    check("core_rst2_2clk", 64'(core_reset_n), 64'd1);
    check("ready_after_rst", 64'(ready), 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
